truth_table_checker: RTL and testbench

- Sequential stimulus-and-response engine for small combinational logic exercises.
- Steps an N-input vector through all 2^N combinations and drives two implementations of the same function: a base expression and its gate-level equivalent.
- Samples both outputs and compares each against an expected truth table supplied as a parameter.
- Reports error counts, which implementation failed, and the first failing vector. This is the self-checking receive side of the exhaustive test sequence the team otherwise checks by eye from printed tables.

---
 rtl/truth_table_checker.sv | 127 ++++++++++++
 tb/tb_truth_table_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table sweep: drives vec through all 2^N_IN values and
// checks two implementations of the same function against EXPECT.
module truth_table_checker #(
    parameter int                    N_IN   = 2,
    parameter logic [2**N_IN-1:0]    EXPECT = 4'b1101,
    parameter int                    SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            s_base,
    input  logic            s_eq,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            base_bad,
    output logic            eq_bad,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int CW = N_IN + 1;
    localparam logic [N_IN-1:0] VMAX = '1;
    localparam logic [3:0] SET = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic [N_IN-1:0] vec_n, ffvec_n;
    logic [CW-1:0]   err_n;
    logic            busy_n, done_n, pass_n;
    logic            bb_n, eb_n, ffv_n;
    logic            base_miss, eq_miss;

    assign base_miss = (s_base != EXPECT[vec]);
    assign eq_miss   = (s_eq != EXPECT[vec]);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        vec_n   = vec;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        err_n   = err_count;
        bb_n    = base_bad;
        eb_n    = eq_bad;
        ffv_n   = first_fail_valid;
        ffvec_n = first_fail_vec;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = HOLD;
                    cnt_n   = SET;
                    vec_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    err_n   = '0;
                    bb_n    = 1'b0;
                    eb_n    = 1'b0;
                    ffv_n   = 1'b0;
                    ffvec_n = '0;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) state_n = SAMPLE;
                else             cnt_n   = cnt - 4'd1;
            end
            SAMPLE: begin
                if (base_miss || eq_miss) begin
                    if (err_count != '1) err_n = err_count + CW'(1);
                    bb_n = base_bad | base_miss;
                    eb_n = eq_bad | eq_miss;
                    if (!first_fail_valid) begin
                        ffv_n   = 1'b1;
                        ffvec_n = vec;
                    end
                end
                if (vec != VMAX) begin
                    vec_n   = vec + N_IN'(1);
                    cnt_n   = SET;
                    state_n = HOLD;
                end else begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    // pass reflects the count including this last sample
                    pass_n  = (err_n == '0);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            vec              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            base_bad         <= 1'b0;
            eq_bad           <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            vec              <= vec_n;
            busy             <= busy_n;
            done             <= done_n;
            pass             <= pass_n;
            err_count        <= err_n;
            base_bad         <= bb_n;
            eq_bad           <= eb_n;
            first_fail_valid <= ffv_n;
            first_fail_vec   <= ffvec_n;
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: four instances sharing clk/reset/start,
// table vectors, random fault patterns and hand-written timing sequences.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] expect_tt = 4'b1101;
    logic [3:0] base_tt = 4'b1101;
    logic [3:0] eq_tt = 4'b1101;
    bit nand_eq = 1'b0;

    // instance a: defaults (N_IN=2, SETTLE=1)
    logic [1:0] vec_a, ffvec_a;
    logic [2:0] err_a;
    logic busy_a, done_a, pass_a, bb_a, eb_a, ffv_a, sb_a, se_a;
    assign sb_a = base_tt[vec_a];
    assign se_a = nand_eq ? ~(~vec_a[1] & vec_a[0]) : eq_tt[vec_a];

    truth_table_checker u_a (
        .clk(clk), .reset(reset), .start(start), .vec(vec_a),
        .s_base(sb_a), .s_eq(se_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .base_bad(bb_a), .eq_bad(eb_a),
        .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
    );

    // instance b: SETTLE=0
    logic [1:0] vec_b, ffvec_b;
    logic [2:0] err_b;
    logic busy_b, done_b, pass_b, bb_b, eb_b, ffv_b, s_b;
    assign s_b = expect_tt[vec_b];

    truth_table_checker #(.SETTLE(0)) u_b (
        .clk(clk), .reset(reset), .start(start), .vec(vec_b),
        .s_base(s_b), .s_eq(s_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .base_bad(bb_b), .eq_bad(eb_b),
        .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
    );

    // instance c: SETTLE=3
    logic [1:0] vec_c, ffvec_c;
    logic [2:0] err_c;
    logic busy_c, done_c, pass_c, bb_c, eb_c, ffv_c, s_c;
    assign s_c = expect_tt[vec_c];

    truth_table_checker #(.SETTLE(3)) u_c (
        .clk(clk), .reset(reset), .start(start), .vec(vec_c),
        .s_base(s_c), .s_eq(s_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .err_count(err_c), .base_bad(bb_c), .eq_bad(eb_c),
        .first_fail_valid(ffv_c), .first_fail_vec(ffvec_c)
    );

    // instance d: 3-input majority
    logic [2:0] vec_d, ffvec_d;
    logic [3:0] err_d;
    logic busy_d, done_d, pass_d, bb_d, eb_d, ffv_d, sb_d, se_d;
    assign sb_d = ($countones(vec_d) >= 2);
    assign se_d = ~(~(vec_d[2] & vec_d[1]) & ~(vec_d[0] & (vec_d[2] | vec_d[1])));

    truth_table_checker #(.N_IN(3), .EXPECT(8'b1110_1000)) u_d (
        .clk(clk), .reset(reset), .start(start), .vec(vec_d),
        .s_base(sb_d), .s_eq(se_d), .busy(busy_d), .done(done_d),
        .pass(pass_d), .err_count(err_d), .base_bad(bb_d), .eq_bad(eb_d),
        .first_fail_valid(ffv_d), .first_fail_vec(ffvec_d)
    );

    typedef struct {
        logic [3:0] btt;
        logic [3:0] ett;
        bit         nd;
        int         err;
        bit         bb;
        bit         eb;
        bit         ffv;
        int         ffvec;
        bit         ps;
    } vec_t;

    vec_t tbl[4];
    int ha[64], hb[64], hc[64];
    int na, nb, nc, nd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_sweep(input bit hold_start);
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        na = -1; nb = -1; nc = -1; nd = -1;
        for (int n = 1; n <= 60; n++) begin
            ha[n-1] = int'(vec_a);
            hb[n-1] = int'(vec_b);
            hc[n-1] = int'(vec_c);
            tick();
            if (done_a && na < 0) na = n;
            if (done_b && nb < 0) nb = n;
            if (done_c && nc < 0) nc = n;
            if (done_d && nd < 0) nd = n;
            if (hold_start && na >= 0) break;
            if (na >= 0 && nb >= 0 && nc >= 0 && nd >= 0) break;
        end
        if (na < 0) chk("sweep_timeout", na, 0);
    endtask

    task automatic wait_all_done();
        int k;
        k = 0;
        while (!(done_a && done_b && done_c && done_d) && k < 100) begin
            tick();
            k++;
        end
        chk("wait_all_done", int'(done_a && done_b && done_c && done_d), 1);
    endtask

    // Reference: count vectors where either implementation disagrees with the
    // expected table, and locate the lowest such vector.
    function automatic void model(input logic [3:0] btt, input logic [3:0] ett,
                                  output int err, output bit bb, output bit eb,
                                  output bit ffv, output int ffvec);
        err = 0; bb = 0; eb = 0; ffv = 0; ffvec = 0;
        for (int v = 0; v < 4; v++) begin
            bit fb, fe;
            fb = (btt[v] != expect_tt[v]);
            fe = (ett[v] != expect_tt[v]);
            if (fb) bb = 1;
            if (fe) eb = 1;
            if (fb || fe) begin
                if (!ffv) ffvec = v;
                ffv = 1;
                err++;
            end
        end
    endfunction

    task automatic chk_a(input string tag, input int err, input bit bb,
                         input bit eb, input bit ffv, input int ffvec,
                         input bit ps);
        chk({tag, "_err"}, int'(err_a), err);
        chk({tag, "_base_bad"}, int'(bb_a), int'(bb));
        chk({tag, "_eq_bad"}, int'(eb_a), int'(eb));
        chk({tag, "_ffv"}, int'(ffv_a), int'(ffv));
        chk({tag, "_ffvec"}, int'(ffvec_a), ffvec);
        chk({tag, "_pass"}, int'(pass_a), int'(ps));
        chk({tag, "_done"}, int'(done_a), 1);
        chk({tag, "_busy"}, int'(busy_a), 0);
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_vec"}, int'(vec_a), 0);
        chk({tag, "_busy"}, int'(busy_a), 0);
        chk({tag, "_done"}, int'(done_a), 0);
        chk({tag, "_pass"}, int'(pass_a), 0);
        chk({tag, "_err"}, int'(err_a), 0);
        chk({tag, "_base_bad"}, int'(bb_a), 0);
        chk({tag, "_eq_bad"}, int'(eb_a), 0);
        chk({tag, "_ffv"}, int'(ffv_a), 0);
        chk({tag, "_ffvec"}, int'(ffvec_a), 0);
    endtask

    initial begin
        // a&~b disagrees with a|~b at 00 and 11 only
        tbl[0] = '{4'b1101, 4'b0000, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1};
        tbl[1] = '{4'b1101, 4'b1111, 1'b0, 1, 1'b0, 1'b1, 1'b1, 1, 1'b0};
        tbl[2] = '{4'b0100, 4'b1101, 1'b0, 2, 1'b1, 1'b0, 1'b1, 0, 1'b0};
        tbl[3] = '{4'b0100, 4'b1111, 1'b0, 3, 1'b1, 1'b1, 1'b1, 0, 1'b0};

        reset = 1'b1;
        start = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk_a_reset("reset");
        chk("reset_d_busy", int'(busy_d), 0);
        chk("reset_d_err", int'(err_d), 0);

        // timing and vec hold lengths, correct implementations everywhere
        base_tt = 4'b1101; nand_eq = 1'b1;
        run_sweep(1'b0);
        chk("time_a", na, 12);
        chk("time_b", nb, 8);
        chk("time_c", nc, 20);
        chk("time_d", nd, 24);
        for (int k = 0; k < 12; k++) chk($sformatf("vec_a_%0d", k), ha[k], k / 3);
        for (int k = 0; k < 8; k++) chk($sformatf("vec_b_%0d", k), hb[k], k / 2);
        for (int k = 0; k < 20; k++) chk($sformatf("vec_c_%0d", k), hc[k], k / 5);
        chk("vec_a_done", int'(vec_a), 3);
        chk("pass_b", int'(pass_b), 1);
        chk("pass_c", int'(pass_c), 1);
        chk("pass_d", int'(pass_d), 1);
        chk("err_d", int'(err_d), 0);
        chk("ffv_d", int'(ffv_d), 0);
        chk("vec_d_done", int'(vec_d), 7);

        foreach (tbl[i]) begin
            base_tt = tbl[i].btt;
            eq_tt = tbl[i].ett;
            nand_eq = tbl[i].nd;
            run_sweep(1'b0);
            chk($sformatf("tbl%0d_time", i), na, 12);
            chk_a($sformatf("tbl%0d", i), tbl[i].err, tbl[i].bb, tbl[i].eb,
                  tbl[i].ffv, tbl[i].ffvec, tbl[i].ps);
        end

        nand_eq = 1'b0;
        for (int r = 0; r < 16; r++) begin
            int e, fv;
            bit b, q, f;
            base_tt = 4'($urandom_range(0, 15));
            eq_tt = 4'($urandom_range(0, 15));
            model(base_tt, eq_tt, e, b, q, f, fv);
            run_sweep(1'b0);
            chk_a($sformatf("rnd%0d", r), e, b, q, f, fv, (e == 0));
        end

        // reset during HOLD of vec=2 in a failing sweep
        base_tt = 4'b0100; eq_tt = 4'b1101;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20 && vec_a != 2'd2; k++) tick();
        chk("rst_mid_vec", int'(vec_a), 2);
        chk("rst_mid_ffv", int'(ffv_a), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_a_reset("rst_mid");
        base_tt = 4'b1101;
        run_sweep(1'b0);
        chk_a("post_rst", 0, 0, 0, 0, 0, 1);

        // start held high: ignored while busy, restarts from DONE
        base_tt = 4'b0100;
        run_sweep(1'b1);
        chk("held_time", na, 12);
        chk("held_err", int'(err_a), 2);
        tick();
        chk("restart_done", int'(done_a), 0);
        chk("restart_busy", int'(busy_a), 1);
        chk("restart_vec", int'(vec_a), 0);
        chk("restart_err", int'(err_a), 0);
        chk("restart_bb", int'(bb_a), 0);
        chk("restart_ffv", int'(ffv_a), 0);
        start = 1'b0;
        wait_all_done();
        chk("restart_final_err", int'(err_a), 2);
        chk("restart_final_ffvec", int'(ffvec_a), 0);
        chk("restart_final_pass_d", int'(pass_d), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
